voq_bank: RTL and testbench
===========================

// Module: voq_bank
// PURPOSE
//  Parametrised virtual-output-queue bank on the switch rx path, after crossbar lookup.
//  Holds frame start pointers (SRAM block indices) in one circular FIFO per egress port.
//  Accepts unicast/multicast enqueue masks; serves independent FWFT dequeue per egress port.
//  Reports per-port accept/drop so freeing logic can refcount multicast frames.
// PARAMETERS
//  NUM_PORTS  4   egress ports = number of queues (>=2)
//  DEPTH      16  entries per queue (>=2, any value, need not be power of 2)
//  ADDR_W     10  width of stored frame start pointer
//  CNT_W      16  width of stats counters (VOQ_STATS_EN only)
// PORTS
//  clk              in   1                   switch clock; all logic on posedge
//  rst              in   1                   synchronous, active-high reset
//  enq_valid_i      in   1                   enqueue request this cycle
//  enq_mask_i       in   NUM_PORTS           target queues; bit p = egress port p
//  enq_ptr_i        in   ADDR_W              frame start pointer to store
//  enq_accept_o     out  NUM_PORTS           registered: queues that took last enqueue
//  enq_drop_o       out  NUM_PORTS           registered: queues that dropped (full)
//  flush_i          in   NUM_PORTS           clear queue p (egress link down)
//  deq_ready_i      in   NUM_PORTS           tx side consumes head of queue p
//  deq_valid_o      out  NUM_PORTS           queue p non-empty
//  deq_ptr_o        out  NUM_PORTS*ADDR_W    head pointer of queue p (slice p)
//  occupancy_o      out  NUM_PORTS*$clog2(DEPTH+1)  entry count per queue
//  drop_cnt_o       out  NUM_PORTS*CNT_W     per-port drop counter (stats)
//  hiwater_o        out  NUM_PORTS*$clog2(DEPTH+1)  per-port max occupancy (stats)
// BEHAVIOUR
//  Only clock is clk; reset is synchronous and active-high (rst).
//  Reset: all counts, rd/wr indices 0; deq_valid_o=0, deq_ptr_o=0, enq_accept_o=0,
//   enq_drop_o=0, occupancy_o=0, drop_cnt_o=0, hiwater_o=0. rst mid-operation discards contents.
//  Per queue p, per cycle: enq_p = enq_valid_i & enq_mask_i[p] & ~flush_i[p];
//   deq_p = deq_valid_o[p] & deq_ready_i[p] & ~flush_i[p].
//  Accept rule: enq_p accepted if count<DEPTH, or count==DEPTH and deq_p same cycle.
//   Otherwise dropped; other masked queues still accept (partial multicast allowed).
//  Accepted: mem[p][wr]<=enq_ptr_i; wr<=(wr==DEPTH-1)?0:wr+1. Same wrap rule for rd on deq_p.
//  count: +1 enq only, -1 deq only, unchanged on both or neither.
//  enq_accept_o[p]/enq_drop_o[p]: one-cycle pulses, registered, 1 cycle after enqueue.
//   enq_valid_i with mask 0 -> both 0. deq_ready_i with deq_valid_o=0 -> ignored.
//  Dequeue FWFT: deq_ptr_o[p]=mem[p][rd] combinationally; deq_valid_o[p]=(count!=0).
//  Enqueue to empty queue: visible on deq_valid_o next cycle (no same-cycle bypass).
//  flush_i[p]: next cycle count=0, rd=wr=0; same-cycle enq/deq to p ignored,
//   enq not reported as accept or drop. Other ports unaffected.
//  occupancy_o[p]=count of p (registered). Max latency enq->deq_valid: 1 cycle.
//  No internal state machine beyond per-queue {EMPTY, PARTIAL, FULL} derived from count.
// CONFIGURATION
//  VOQ_STATS_EN defined: drop_cnt_o[p] +1 (saturating at 2^CNT_W-1) per drop of p;
//   hiwater_o[p] <= max(hiwater, next count); both cleared only by rst (not by flush).
//  VOQ_STATS_EN undefined: drop_cnt_o and hiwater_o tied to 0; no counter flops.
//  Queue behaviour identical in both builds.
// TESTING
//  1. Unicast: DEPTH=16, enq ptr 0x005 mask 4'b0010 -> next cycle accept=4'b0010,
//     deq_valid_o=4'b0010, deq_ptr_o[1]=0x005; deq_ready_i[1] -> valid drops next cycle.
//  2. Fill port 0 with 16 ptrs 0..15, 17th (0x3FF) -> drop_o=4'b0001, occupancy 16;
//     drain -> 0..15 in order, wrap: next enq lands at index 0.
//  3. Multicast mask 4'b1111 with port 2 full -> accept=4'b1011, drop=4'b0100;
//     STATS build drop_cnt_o[2]=1.
//  4. Port 3 full, enq+deq same cycle -> accepted, occupancy stays 16, FIFO order kept.
//  5. flush_i=4'b0001 with enq mask 4'b0001 same cycle -> occupancy 0, accept=drop=0;
//     ports 1..3 contents intact.
//  6. rst asserted mid-traffic (all queues half full) -> all outputs 0 next cycle;
//     STATS build hiwater_o recorded 8 before reset, 0 after.

Source files
------------

// File: rtl/voq_bank.sv
// Virtual-output-queue bank: one circular FIFO of frame start pointers per egress port.
// Optional VOQ_STATS_EN build adds per-port saturating drop counters and occupancy high-water marks.

module voq_lane #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16,
  parameter int OCC_W  = $clog2(DEPTH+1),
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_req,
  input  logic              deq_req,
  input  logic              flush,
  input  logic [ADDR_W-1:0] enq_ptr,
  output logic              deq_valid,
  output logic [ADDR_W-1:0] deq_ptr,
  output logic [OCC_W-1:0]  occupancy,
  output logic              accept,
  output logic              drop,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [OCC_W-1:0]  hiwater
);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  rd, wr;
  logic [OCC_W-1:0]  count, count_nxt;
  logic              empty, full, enq, deq, acc, drp;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(DEPTH-1)) ? '0 : i + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == OCC_W'(DEPTH));
  assign enq   = enq_req & ~flush;
  assign deq   = ~empty & deq_req & ~flush;
  // A full queue still takes an entry when its head leaves in the same cycle.
  assign acc   = enq & (~full | deq);
  assign drp   = enq & ~acc;

  always_comb begin
    count_nxt = count;
    if (flush)           count_nxt = '0;
    else if (acc && !deq) count_nxt = count + 1'b1;
    else if (deq && !acc) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rd     <= '0;
      wr     <= '0;
      accept <= 1'b0;
      drop   <= 1'b0;
    end else begin
      count  <= count_nxt;
      accept <= acc;
      drop   <= drp;
      if (flush) begin
        rd <= '0;
        wr <= '0;
      end else begin
        if (acc) wr <= wrap_inc(wr);
        if (deq) rd <= wrap_inc(rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem[wr] <= enq_ptr;
  end

  // Empty queues present a zero head so reset and drained state look identical.
  assign deq_valid = ~empty;
  assign deq_ptr   = empty ? '0 : mem[rd];
  assign occupancy = count;

`ifdef VOQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      hiwater  <= '0;
    end else begin
      if (drp && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      if (count_nxt > hiwater)     hiwater  <= count_nxt;
    end
  end
`else
  assign drop_cnt = '0;
  assign hiwater  = '0;
`endif

endmodule

module voq_bank #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 10,
  parameter int CNT_W     = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      enq_valid_i,
  input  logic [NUM_PORTS-1:0]                      enq_mask_i,
  input  logic [ADDR_W-1:0]                         enq_ptr_i,
  output logic [NUM_PORTS-1:0]                      enq_accept_o,
  output logic [NUM_PORTS-1:0]                      enq_drop_o,
  input  logic [NUM_PORTS-1:0]                      flush_i,
  input  logic [NUM_PORTS-1:0]                      deq_ready_i,
  output logic [NUM_PORTS-1:0]                      deq_valid_o,
  output logic [NUM_PORTS*ADDR_W-1:0]               deq_ptr_o,
  output logic [NUM_PORTS*$clog2(DEPTH+1)-1:0]      occupancy_o,
  output logic [NUM_PORTS*CNT_W-1:0]                drop_cnt_o,
  output logic [NUM_PORTS*$clog2(DEPTH+1)-1:0]      hiwater_o
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    voq_lane #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W),
      .OCC_W (OCC_W),
      .IDX_W (IDX_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .enq_req  (enq_valid_i & enq_mask_i[p]),
      .deq_req  (deq_ready_i[p]),
      .flush    (flush_i[p]),
      .enq_ptr  (enq_ptr_i),
      .deq_valid(deq_valid_o[p]),
      .deq_ptr  (deq_ptr_o[p*ADDR_W +: ADDR_W]),
      .occupancy(occupancy_o[p*OCC_W +: OCC_W]),
      .accept   (enq_accept_o[p]),
      .drop     (enq_drop_o[p]),
      .drop_cnt (drop_cnt_o[p*CNT_W +: CNT_W]),
      .hiwater  (hiwater_o[p*OCC_W +: OCC_W])
    );
  end

endmodule

// File: tb/tb_voq_bank.sv
// Scoreboard bench for voq_bank: a queue-based reference model predicts every cycle's outputs.
module tb_voq_bank;
  localparam int NP = 4, DEPTH = 16, AW = 10, CW = 16, OW = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst, enq_valid_i;
  logic [NP-1:0] enq_mask_i, flush_i, deq_ready_i;
  logic [AW-1:0] enq_ptr_i;
  logic [NP-1:0] enq_accept_o, enq_drop_o, deq_valid_o;
  logic [NP*AW-1:0] deq_ptr_o;
  logic [NP*OW-1:0] occupancy_o, hiwater_o;
  logic [NP*CW-1:0] drop_cnt_o;

  always #5 clk = ~clk;

  voq_bank #(.NUM_PORTS(NP), .DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enq_valid_i(enq_valid_i), .enq_mask_i(enq_mask_i),
    .enq_ptr_i(enq_ptr_i), .enq_accept_o(enq_accept_o), .enq_drop_o(enq_drop_o),
    .flush_i(flush_i), .deq_ready_i(deq_ready_i), .deq_valid_o(deq_valid_o),
    .deq_ptr_o(deq_ptr_o), .occupancy_o(occupancy_o), .drop_cnt_o(drop_cnt_o),
    .hiwater_o(hiwater_o));

  typedef struct {
    logic          rst_seen;
    logic [NP-1:0] acc, drp, vld;
    int            ptr [NP];
    int            occ [NP];
    int            dcnt[NP];
    int            hw  [NP];
  } exp_t;

  exp_t expq[$];
  int   mq[NP][$];
  int   mdc[NP];
  int   mhw[NP];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int p, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s port %0d: got %0h expected %0h", nm, p, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh set of outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        for (int p = 0; p < NP; p++) begin
          chk("accept", p, 32'(enq_accept_o[p]), 32'(e.acc[p]));
          chk("drop",   p, 32'(enq_drop_o[p]),   32'(e.drp[p]));
          chk("valid",  p, 32'(deq_valid_o[p]),  32'(e.vld[p]));
          chk("occupancy", p, 32'(occupancy_o[p*OW +: OW]), e.occ[p]);
          if (e.vld[p] || e.rst_seen)
            chk("head_ptr", p, 32'(deq_ptr_o[p*AW +: AW]), e.ptr[p]);
          chk("drop_cnt", p, 32'(drop_cnt_o[p*CW +: CW]), e.dcnt[p]);
          chk("hiwater",  p, 32'(hiwater_o[p*OW +: OW]),  e.hw[p]);
        end
      end
    end
  end

  // Drive one cycle of stimulus and push the model's prediction for the following edge.
  task automatic step(input bit r, input bit ev, input logic [NP-1:0] m,
                      input logic [AW-1:0] ptr, input logic [NP-1:0] fl, input logic [NP-1:0] rdy);
    exp_t e;
    @(negedge clk);
    rst = r; enq_valid_i = ev; enq_mask_i = m; enq_ptr_i = ptr; flush_i = fl; deq_ready_i = rdy;
    e.rst_seen = r;
    e.acc = '0; e.drp = '0; e.vld = '0;
    for (int p = 0; p < NP; p++) begin
      if (r) begin
        mq[p].delete(); mdc[p] = 0; mhw[p] = 0;
      end else if (fl[p]) begin
        mq[p].delete();
      end else begin
        if (mq[p].size() != 0 && rdy[p]) void'(mq[p].pop_front());
        if (ev && m[p]) begin
          if (mq[p].size() < DEPTH) begin
            mq[p].push_back(int'(ptr)); e.acc[p] = 1'b1;
          end else begin
            e.drp[p] = 1'b1;
            if (mdc[p] < (1 << CW) - 1) mdc[p]++;
          end
        end
      end
      if (mq[p].size() > mhw[p]) mhw[p] = mq[p].size();
      e.vld[p] = (mq[p].size() != 0);
      e.ptr[p] = e.vld[p] ? mq[p][0] : 0;
      e.occ[p] = mq[p].size();
`ifdef VOQ_STATS_EN
      e.dcnt[p] = mdc[p]; e.hw[p] = mhw[p];
`else
      e.dcnt[p] = 0; e.hw[p] = 0;
`endif
    end
    expq.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, '0, '0, '0, '0);
  endtask

  initial begin
    rst = 1'b1; enq_valid_i = 1'b0; enq_mask_i = '0; enq_ptr_i = '0; flush_i = '0; deq_ready_i = '0;
    step(1, 0, '0, '0, '0, '0);
    step(1, 0, '0, '0, '0, '0);

    // unicast enqueue to port 1, then dequeue
    step(0, 1, 4'b0010, 10'h005, '0, '0);
    idle();
    step(0, 0, '0, '0, '0, 4'b0010);
    idle();

    // fill port 0, overflow, drain in order, then wrap
    for (int i = 0; i < 16; i++) step(0, 1, 4'b0001, AW'(i), '0, '0);
    step(0, 1, 4'b0001, 10'h3FF, '0, '0);
    for (int i = 0; i < 16; i++) step(0, 0, '0, '0, '0, 4'b0001);
    step(0, 1, 4'b0001, 10'h2AA, '0, '0);
    step(0, 0, '0, '0, '0, 4'b0001);

    // multicast with port 2 full
    for (int i = 0; i < 16; i++) step(0, 1, 4'b0100, AW'(i + 32), '0, '0);
    step(0, 1, 4'b1111, 10'h111, '0, '0);

    // port 3 full, enqueue + dequeue together
    for (int i = 0; i < 15; i++) step(0, 1, 4'b1000, AW'(i + 64), '0, '0);
    step(0, 1, 4'b1000, 10'h1F0, '0, 4'b1000);
    for (int i = 0; i < 3; i++) step(0, 0, '0, '0, '0, 4'b1000);

    // flush port 0 with a same-cycle enqueue
    step(0, 1, 4'b0001, 10'h055, '0, '0);
    step(0, 1, 4'b0001, 10'h056, 4'b0001, '0);
    idle();

    // reset mid-traffic with all queues half full
    step(1, 0, '0, '0, '0, '0);
    for (int i = 0; i < 8; i++) step(0, 1, 4'b1111, AW'(i + 100), '0, '0);
    idle();
    step(1, 0, '0, '0, '0, '0);
    idle();

    // randomized traffic: alternating fill-heavy and drain-heavy phases
    for (int i = 0; i < 3000; i++) begin
      logic [NP-1:0] rdy, fl;
      bit fill_phase;
      fill_phase = ((i / 200) % 2) == 0;
      rdy = NP'($urandom) & (fill_phase ? NP'($urandom) & NP'($urandom) : NP'($urandom) | NP'($urandom));
      fl = '0;
      for (int p = 0; p < NP; p++) if ($urandom_range(0, 63) == 0) fl[p] = 1'b1;
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 9) < 7), NP'($urandom),
           AW'($urandom), fl, rdy);
    end
    idle();
    idle();

    for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge clk);
    #2;
    n_chk++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain port 0: got %0d pending expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
